// File: rtl/udiv_slt_skolem_checker_if.sv
// Handshake bundle for udiv_slt_skolem_checker: operand input channel and result output channel.
// master drives operands and out_ready; slave is the checker.
interface udiv_slt_skolem_checker_if #(
    parameter int unsigned W = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic [W-1:0] x;
    logic         out_valid;
    logic         out_ready;
    logic         out_holds;
    logic [W-1:0] out_q;
    logic         out_div0;

    modport master (
        output in_valid, s, t, x, out_ready,
        input  in_ready, out_valid, out_holds, out_q, out_div0
    );

    modport slave (
        input  in_valid, s, t, x, out_ready,
        output in_ready, out_valid, out_holds, out_q, out_div0
    );
endinterface

// File: rtl/udiv_slt_skolem_checker.sv
// Checks a Skolem candidate x for bvudiv/bvslt: q = x udiv s (serial restoring), holds = q <s t.
// Optional macro FAIL_COUNT_EN adds a saturating 16-bit count of failing results (fail_cnt).
module udiv_slt_skolem_checker #(
    parameter int unsigned W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    udiv_slt_skolem_checker_if.slave  bus
`ifdef FAIL_COUNT_EN
    ,
    output logic [15:0]               fail_cnt
`endif
);
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StDiv, StCmp, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  oq_q, oq_d;
    logic          holds_q, holds_d;
    logic          div0_q, div0_d;
    logic [W:0]    r_shift;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        r_d     = r_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        oq_d    = oq_q;
        holds_d = holds_q;
        div0_d  = div0_q;
        // Stored remainder is always < s, so W bits suffice; the shifted trial value needs W+1.
        r_shift = {r_q, quo_q[W-1]};
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    s_d     = bus.s;
                    t_d     = bus.t;
                    quo_d   = bus.x;
                    r_d     = '0;
                    cnt_d   = CntW'(W - 1);
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (r_shift >= {1'b0, s_q}) begin
                    r_d   = W'(r_shift - {1'b0, s_q});
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    r_d   = r_shift[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                oq_d    = quo_q;
                div0_d  = (s_q == '0);
                holds_d = $signed(quo_q) < $signed(t_q);
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            t_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            oq_q    <= '0;
            holds_q <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            t_q     <= t_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            oq_q    <= oq_d;
            holds_q <= holds_d;
            div0_q  <= div0_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_q     = oq_q;
    assign bus.out_holds = holds_q;
    assign bus.out_div0  = div0_q;

`ifdef FAIL_COUNT_EN
    logic [15:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if ((state_q == StDone) && bus.out_ready && !holds_q && (fail_cnt_q != 16'hFFFF)) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail_cnt = fail_cnt_q;
`endif
endmodule
